// File: rtl/button_param_scheduler.sv
// Debounced inc/dec/select buttons step one of N_PARAM saturating parameters.
// Define BUTTON_AUTO_REPEAT_EN to make a held inc/dec button step repeatedly.
module button_param_scheduler #(
  parameter int N_PARAM       = 4,
  parameter int N_BIT         = 8,
  parameter int STEP          = 1,
  parameter int VAL_MIN       = 0,
  parameter int VAL_MAX       = 255,
  parameter int VAL_RST       = 0,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic                       i_inc_btn,
  input  logic                       i_dec_btn,
  input  logic                       i_sel_btn,
  output logic [N_PARAM*N_BIT-1:0]   o_params,
  output logic [N_BIT-1:0]           o_value,
  output logic [$clog2(N_PARAM)-1:0] o_sel,
  output logic                       o_update
);

  localparam int SW = $clog2(N_PARAM);
  localparam int W1 = N_BIT + 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [W1-1:0] L_STEP     = W1'(STEP);
  localparam logic [W1-1:0] L_MAX      = W1'(VAL_MAX);
  localparam logic [W1-1:0] L_MIN_STEP = W1'(VAL_MIN + STEP);
  localparam logic [DW-1:0] L_DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] L_SEL_LAST = SW'(N_PARAM - 1);

  if (N_PARAM < 2 || DEBOUNCE_CYC < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_param_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_LOCK
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_last;
  logic [2:0]        r_deb;
  logic [2:0]        r_hold;
  logic [DW-1:0]     r_db_cnt;
  logic [2:0]        w_pressed;
  logic [N_BIT-1:0]  r_params [N_PARAM];
  logic [SW-1:0]     r_sel;
  logic              r_update;
  logic              w_do_inc;
  logic              w_do_dec;
  logic              w_do_sel;
  logic              w_load_hold;
  logic              w_expire;
  logic [N_BIT-1:0]  w_cur_val;
  logic [N_BIT-1:0]  w_new_val;
  logic [W1-1:0]     w_cur;
  logic [W1-1:0]     w_inc_sum;

  // Buttons are active-low; P = {sel,dec,inc} pressed
  assign w_pressed = ~r_sync2;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_sync1  <= 3'b111;
      r_sync2  <= 3'b111;
      r_last   <= '0;
      r_db_cnt <= '0;
      r_deb    <= '0;
    end else begin
      r_sync1 <= {i_sel_btn, i_dec_btn, i_inc_btn};
      r_sync2 <= r_sync1;
      if (w_pressed != r_last) begin
        r_last   <= w_pressed;
        r_db_cnt <= '0;
      end else if (r_db_cnt != L_DB_LAST) begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end else begin
        r_deb <= r_last;
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX + 1);

  logic [TW-1:0] r_timer;

  assign w_expire = (r_timer <= TW'(1));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_timer <= '0;
    end else if (w_load_hold) begin
      r_timer <= TW'(REPEAT_DELAY);
    end else if (r_state == S_HOLD && w_state_nx == S_HOLD) begin
      if (w_expire) r_timer <= TW'(REPEAT_PERIOD);
      else          r_timer <= r_timer - TW'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_do_inc    = 1'b0;
    w_do_dec    = 1'b0;
    w_do_sel    = 1'b0;
    w_load_hold = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if ($onehot(r_deb)) begin
          w_do_inc    = r_deb[0];
          w_do_dec    = r_deb[1];
          w_do_sel    = r_deb[2];
          w_load_hold = 1'b1;
          w_state_nx  = S_HOLD;
        end else if (r_deb != 3'b000) begin
          w_state_nx = S_LOCK;
        end
      end
      S_HOLD: begin
        if (r_deb == 3'b000) begin
          w_state_nx = S_IDLE;
        end else if (r_deb != r_hold) begin
          w_state_nx = S_LOCK;
        end else if (w_expire && !r_hold[2]) begin
          w_do_inc = r_hold[0];
          w_do_dec = r_hold[1];
        end
      end
      S_LOCK: begin
        if (r_deb == 3'b000) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Saturation tests run one bit wider so nothing wraps
  assign w_cur_val = r_params[r_sel];
  assign w_cur     = {1'b0, w_cur_val};
  assign w_inc_sum = w_cur + L_STEP;

  always_comb begin
    w_new_val = w_cur_val;
    unique case (1'b1)
      w_do_inc:
        w_new_val = (w_inc_sum > L_MAX) ?
                    N_BIT'(VAL_MAX) : w_inc_sum[N_BIT-1:0];
      w_do_dec:
        w_new_val = (w_cur < L_MIN_STEP) ?
                    N_BIT'(VAL_MIN) : N_BIT'(w_cur - L_STEP);
      default: w_new_val = w_cur_val;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state  <= S_IDLE;
      r_hold   <= '0;
      r_sel    <= '0;
      r_update <= 1'b0;
      for (int k = 0; k < N_PARAM; k++) begin
        r_params[k] <= N_BIT'(VAL_RST);
      end
    end else begin
      r_state <= w_state_nx;
      if (w_load_hold) r_hold <= r_deb;
      if (w_do_sel) begin
        r_sel <= (r_sel == L_SEL_LAST) ? '0 : r_sel + SW'(1);
      end
      r_params[r_sel] <= w_new_val;
      r_update        <= (w_new_val != w_cur_val);
    end
  end

  for (genvar k = 0; k < N_PARAM; k++) begin : g_out
    assign o_params[k*N_BIT +: N_BIT] = r_params[k];
  end

  assign o_value  = w_cur_val;
  assign o_sel    = r_sel;
  assign o_update = r_update;

endmodule

// File: tb/tb_button_param_scheduler.sv
// Directed bench for button_param_scheduler: debounce latency, saturation,
// selection, lock-out, glitch rejection, reset mid-hold and auto-repeat.
module tb_button_param_scheduler;

  localparam int NP = 3;
  localparam int NB = 8;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              inc_n;
  logic              dec_n;
  logic              sel_n;
  logic [NP*NB-1:0]  params;
  logic [NB-1:0]     value;
  logic [SW-1:0]     sel;
  logic              upd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] btn;
    int         p0;
    int         p1;
    int         p2;
    int         sel;
    int         pulses;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  button_param_scheduler #(
    .N_PARAM      (NP),
    .N_BIT        (NB),
    .STEP         (3),
    .VAL_MIN      (2),
    .VAL_MAX      (10),
    .VAL_RST      (5),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (16),
    .REPEAT_PERIOD(4)
  ) dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_inc_btn(inc_n),
    .i_dec_btn(dec_n),
    .i_sel_btn(sel_n),
    .o_params (params),
    .o_value  (value),
    .o_sel    (sel),
    .o_update (upd)
  );

  function automatic int p(input int k);
    return int'(params[k*NB +: NB]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [2:0] pr, input int cyc,
                     output int pulses);
    {sel_n, dec_n, inc_n} = ~pr;
    pulses = 0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      if (upd) pulses++;
    end
  endtask

  task automatic press(input logic [2:0] pr, output int pulses);
    int a;
    int b;
    run(pr, 10, a);
    run(3'b000, 10, b);
    pulses = a + b;
  endtask

  initial begin
    int pl;
    int pl2;
    int pl3;
    int exp_v;
    int exp_u;
    int exp_p0;
    int ev;

    tbl[0]  = '{3'b001, 10, 5, 5, 0, 1};
    tbl[1]  = '{3'b001, 10, 5, 5, 0, 0};
    tbl[2]  = '{3'b010,  7, 5, 5, 0, 1};
    tbl[3]  = '{3'b010,  4, 5, 5, 0, 1};
    tbl[4]  = '{3'b010,  2, 5, 5, 0, 1};
    tbl[5]  = '{3'b100,  2, 5, 5, 1, 0};
    tbl[6]  = '{3'b100,  2, 5, 5, 2, 0};
    tbl[7]  = '{3'b100,  2, 5, 5, 0, 0};
    tbl[8]  = '{3'b100,  2, 5, 5, 1, 0};
    tbl[9]  = '{3'b001,  2, 8, 5, 1, 1};
    tbl[10] = '{3'b100,  2, 8, 5, 2, 0};
    tbl[11] = '{3'b100,  2, 8, 5, 0, 0};

    rst   = 1'b1;
    inc_n = 1'b1;
    dec_n = 1'b1;
    sel_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_p0", p(0), 5);
    chk("rst_p1", p(1), 5);
    chk("rst_p2", p(2), 5);
    chk("rst_sel", int'(sel), 0);
    chk("rst_upd", int'(upd), 0);
    chk("rst_value", int'(value), 5);

    rst = 1'b0;
    run(3'b000, 5, pl);
    chk("idle_pulses", pl, 0);

    // First press: step lands exactly at edge 7
    inc_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_p0_e%0d", e), p(0), (e >= 7) ? 8 : 5);
      chk($sformatf("lat_upd_e%0d", e), int'(upd), (e == 7) ? 1 : 0);
    end
    run(3'b000, 10, pl);
    chk("lat_rel_pulses", pl, 0);
    chk("lat_rel_p0", p(0), 8);

    for (int i = 0; i < 12; i++) begin
      press(tbl[i].btn, pl);
      chk($sformatf("v%0d_p0", i), p(0), tbl[i].p0);
      chk($sformatf("v%0d_p1", i), p(1), tbl[i].p1);
      chk($sformatf("v%0d_p2", i), p(2), tbl[i].p2);
      chk($sformatf("v%0d_sel", i), int'(sel), tbl[i].sel);
      ev = (tbl[i].sel == 0) ? tbl[i].p0 :
           (tbl[i].sel == 1) ? tbl[i].p1 : tbl[i].p2;
      chk($sformatf("v%0d_value", i), int'(value), ev);
      chk($sformatf("v%0d_pulses", i), pl, tbl[i].pulses);
    end

    // Long hold of inc on param0 starting from 2
    exp_v = 2;
    {sel_n, dec_n, inc_n} = 3'b110;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      exp_u = 0;
      if (e == 7) begin
        exp_v = 5;
        exp_u = 1;
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      if (e == 23) begin
        exp_v = 8;
        exp_u = 1;
      end
      if (e == 27) begin
        exp_v = 10;
        exp_u = 1;
      end
`endif
      chk($sformatf("rep_p0_e%0d", e), p(0), exp_v);
      chk($sformatf("rep_upd_e%0d", e), int'(upd), exp_u);
    end
    run(3'b000, 10, pl);
    chk("rep_rel_pulses", pl, 0);
    exp_p0 = exp_v;

    // Two buttons together lock out all actions until full release
    run(3'b011, 10, pl);
    run(3'b001, 20, pl2);
    run(3'b000, 10, pl3);
    chk("lock_pulses", pl + pl2 + pl3, 0);
    chk("lock_p0", p(0), exp_p0);
    chk("lock_p1", p(1), 8);

    press(3'b010, pl);
    exp_p0 = (exp_p0 < 5) ? 2 : exp_p0 - 3;
    chk("after_lock_p0", p(0), exp_p0);
    chk("after_lock_pulses", pl, 1);

    // A 3-cycle glitch is shorter than the debounce window
    run(3'b001, 3, pl);
    run(3'b000, 12, pl2);
    chk("glitch_pulses", pl + pl2, 0);
    chk("glitch_p0", p(0), exp_p0);

    press(3'b100, pl);
    chk("pre_rst_sel", int'(sel), 1);
    run(3'b001, 12, pl);
    chk("pre_rst_pulses", pl, 1);
    chk("pre_rst_p1", p(1), 10);

    // Reset while inc is still held
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_p0", p(0), 5);
    chk("mid_rst_p1", p(1), 5);
    chk("mid_rst_p2", p(2), 5);
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_upd", int'(upd), 0);

    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_p0_e%0d", e), p(0), (e >= 7) ? 8 : 5);
      chk($sformatf("post_rst_upd_e%0d", e), int'(upd),
          (e == 7) ? 1 : 0);
    end
    run(3'b000, 10, pl);
    chk("post_rst_rel_pulses", pl, 0);
    chk("post_rst_p1", p(1), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
